// File: rtl/rf_arb_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
// Shared definitions for the register-file read-port arbiter:
//   - register index / data widths of the core's 16-entry read mux
//   - FSM state encodings (IDLE, WAIT, ACK); code 2'd3 is unused and
//     recovers to IDLE.
// No ports (package).
// -----------------------------------------------------------------------------
package rf_arb_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_WAIT = WAIT,
    ST_ACK  = ACK
  } arb_state_t;

endpackage

// File: rtl/rf_arb_starve_counter.sv
// -----------------------------------------------------------------------------
// rf_arb_starve_counter
// Counts cycles a debug request has been denied. Clears on request, saturates
// at STARVE_LIMIT and flags force_grant once the limit is reached.
// Ports:
//   clk          in   core clock
//   reset        in   synchronous active-high reset
//   clear        in   return count to zero (takes priority over inc)
//   inc          in   one more denied cycle
//   force_grant  out  count has reached STARVE_LIMIT
// -----------------------------------------------------------------------------
module rf_arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic force_grant
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != LIMIT)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign force_grant = (cnt_reg == LIMIT);

endmodule

// File: rtl/rf_read_port_arbiter.sv
// -----------------------------------------------------------------------------
// rf_read_port_arbiter
// Shares the two read selects of the register-file read mux between the core
// datapath and a debug register reader. Port 1 always belongs to the core.
// Port 2 is lent to debug on cycles the core is idle or, when RF_ARB_STARVE_EN
// is defined, forcibly after STARVE_LIMIT denied cycles (core stalled for that
// single cycle). Without RF_ARB_STARVE_EN debug waits for an idle core cycle
// and core_stall is tied low; STARVE_LIMIT is then accepted but unused.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   core_valid               core needs both read ports this cycle
//   core_sel1, core_sel2     core register indices
//   core_stall               core must hold its instruction (port 2 stolen)
//   dbg_req, dbg_sel         debug read request (level) and register index
//   dbg_ack, dbg_data        one-cycle ack pulse and captured register value
//   rf_sel1, rf_sel2         read mux selects
//   rf_rd2                   read mux output 2
// Configuration macro: RF_ARB_STARVE_EN
// -----------------------------------------------------------------------------
module rf_read_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_valid,
  input  logic [REG_IDX_W-1:0] core_sel1,
  input  logic [REG_IDX_W-1:0] core_sel2,
  output logic                 core_stall,
  input  logic                 dbg_req,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic                 dbg_ack,
  output logic [DATA_W-1:0]    dbg_data,
  output logic [REG_IDX_W-1:0] rf_sel1,
  output logic [REG_IDX_W-1:0] rf_sel2,
  input  logic [DATA_W-1:0]    rf_rd2
);

  arb_state_t          state_reg;
  arb_state_t          state_next;
  logic                dbg_ack_reg;
  logic [DATA_W-1:0]   dbg_data_reg;
  logic                can_lend;
  logic                grant;
  logic                force_grant;

  // Debug can only be served while not already acknowledging; reset masks
  // the grant so no select is stolen during reset.
  assign can_lend = (state_reg == ST_IDLE) || (state_reg == ST_WAIT);
  assign grant    = ~reset & dbg_req & can_lend & (~core_valid | force_grant);

`ifdef RF_ARB_STARVE_EN
  logic cnt_inc;

  // Every denied cycle of a live request counts; anything else (grant,
  // abandon, ACK, no request) returns the count to zero.
  assign cnt_inc = dbg_req & can_lend & ~grant;

  rf_arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk         (clk),
    .reset       (reset),
    .clear       (~cnt_inc),
    .inc         (cnt_inc),
    .force_grant (force_grant)
  );

  assign core_stall = grant & core_valid;
`else
  logic [31:0] unused_starve_limit;

  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign force_grant         = 1'b0;
  assign core_stall          = 1'b0;
`endif

  assign rf_sel1 = core_sel1;
  assign rf_sel2 = grant ? dbg_sel : core_sel2;

  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: begin
        if (grant) begin
          state_next = ST_ACK;
        end else if (dbg_req) begin
          state_next = ST_WAIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!dbg_req) begin
          state_next = ST_IDLE;
        end else if (grant) begin
          state_next = ST_ACK;
        end else begin
          state_next = ST_WAIT;
        end
      end
      // dbg_req is ignored here; a still-high request restarts from IDLE.
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      dbg_ack_reg  <= 1'b0;
      dbg_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      dbg_ack_reg <= grant;
      if (grant) begin
        dbg_data_reg <= rf_rd2;
      end
    end
  end

  assign dbg_ack  = dbg_ack_reg;
  assign dbg_data = dbg_data_reg;

endmodule

// File: doc/rf_read_port_arbiter.md
# rf_read_port_arbiter

Arbiter that shares the two read-select ports of the core's 16-entry register-file read mux (dual-output, 4-bit selects, 32-bit data) between the single-cycle core datapath and a debug register-read requester. Port 1 always belongs to the core. Port 2 is lent to debug when the core is idle, or forcibly after a bounded wait, in which case the core is stalled for that cycle. The block sits between the core control path, the debug interface and the register-file read mux.

## Interface
- STARVE_LIMIT, 4: denied cycles tolerated before debug is force-granted; legal range 1..255.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- core_valid  in  1  core needs both read ports this cycle.
- core_sel1  in  4  core register index for port 1.
- core_sel2  in  4  core register index for port 2.
- core_stall  out  1  core must hold its instruction this cycle (port 2 stolen).
- dbg_req  in  1  debug read request; level, held until dbg_ack.
- dbg_sel  in  4  debug register index; stable while dbg_req is high.
- dbg_ack  out  1  one-cycle pulse; dbg_data valid.
- dbg_data  out  32  captured register value.
- rf_sel1  out  4  to read mux select 1.
- rf_sel2  out  4  to read mux select 2.
- rf_rd2  in  32  read mux output 2.

## Operation
- States: IDLE, WAIT, ACK.
- grant (combinational) = ~reset & dbg_req & (state ∈ {IDLE, WAIT}) & (~core_valid | force).
- force = (starve_cnt == STARVE_LIMIT).
- rf_sel1 = core_sel1 always.
- rf_sel2 = grant ? dbg_sel : core_sel2.
- core_stall = grant & core_valid.
- IDLE: if grant, go to ACK. Else if dbg_req, go to WAIT and set starve_cnt to 1. Else stay, starve_cnt = 0.
- WAIT: if ~dbg_req, abandon: go to IDLE, starve_cnt = 0. If grant, go to ACK. Else starve_cnt += 1 (saturating at STARVE_LIMIT).
- Grant cycle: on the closing edge, dbg_data <= rf_rd2 and dbg_ack <= 1. State goes to ACK and starve_cnt = 0.
- ACK: dbg_ack is high for exactly this cycle. dbg_req is ignored in this cycle. Next state is IDLE. A still-high dbg_req is treated as a new request from IDLE.
- starve_cnt width: $clog2(STARVE_LIMIT+1).
- dbg_data holds its last captured value until the next grant.

## Timing
- Reset values: state IDLE, starve_cnt 0, dbg_ack 0, dbg_data 0. During reset, core_stall is 0 and rf_sel2 = core_sel2.
- Latency, core idle: request in cycle n grants in cycle n; dbg_ack in n+1. Best case is 1 cycle.
- Latency, core continuously valid: request in cycle n, denied n..n+STARVE_LIMIT-1, forced grant and core_stall in n+STARVE_LIMIT, dbg_ack in n+STARVE_LIMIT+1.
- Minimum spacing between back-to-back debug reads: 2 cycles (grant, ACK).
- core_stall is asserted for at most 1 cycle per debug read.
- Simultaneous events:
  - core_valid falls in the same cycle force is reached: grant without stall.
  - dbg_req falls in the same cycle as a would-be grant: no grant, no capture.
- Reset mid-operation (WAIT or ACK): the pending request or ack is dropped with no ack. The requester re-issues.

## Configuration
- RF_ARB_STARVE_EN defined: forced grant as above; starve_cnt and STARVE_LIMIT present.
- RF_ARB_STARVE_EN undefined:
  - force = 0 and starve_cnt is removed; core_stall is tied to 0.
  - Debug is granted only on cycles with ~core_valid, so debug may wait indefinitely.
  - STARVE_LIMIT is accepted but unused.

## Structure
- Package rf_arb_pkg holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, ACK=2'd2; 2'd3 recovers to IDLE);
  - REG_IDX_W=4 and DATA_W=32.
- One natural sub-module, rf_arb_starve_counter: clear, increment, saturate at STARVE_LIMIT, outputs force. It is instantiated only under RF_ARB_STARVE_EN.
- FSM, select muxing and capture register stay in the top module.

## Test plan
- Idle core: register 5 holds 0xDEADBEEF; dbg_req=1, dbg_sel=5, core_valid=0 at cycle 0 -> rf_sel2=5 in cycle 0, dbg_ack=1 and dbg_data=0xDEADBEEF in cycle 1, core_stall never high.
- Busy core, STARVE_LIMIT=4: core_valid=1 throughout, core_sel2=3, dbg_sel=9 from cycle 0:
  - rf_sel2=3 in cycles 0-3;
  - rf_sel2=9 and core_stall=1 in cycle 4;
  - dbg_ack in cycle 5;
  - rf_sel2=3 again in cycle 5.
- Abandon: dbg_req high in cycles 0-1 with busy core, low in cycle 2 -> no grant, no ack, state IDLE in cycle 3, starve_cnt 0.
- Back-to-back: dbg_req held high with the core idle -> acks in cycles 1, 3, 5 and grants in cycles 0, 2, 4. dbg_sel changed 7 -> 8 after the first ack returns r7 then r8.
- Reset in WAIT: assert reset in cycle 2 of a busy-core request -> no dbg_ack, core_stall=0, dbg_data=0 after reset, rf_sel2=core_sel2.
- Build without RF_ARB_STARVE_EN: busy core for 20 cycles -> no grant and core_stall never high. Drop core_valid in cycle 20 -> grant in 20, ack in 21.
